// File: rtl/my_alu_core.sv
// Register-fed 8-bit ALU: push-buttons capture a shared switch bus into
// operand A, operand B or the opcode; the result is combinational from them.
module my_alu_core #(
    parameter int unsigned BUS_SIZE = 8,
    parameter int unsigned OP_SIZE  = 6
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [BUS_SIZE-1:0] i_swiches,
    input  logic                i_boton1,
    input  logic                i_boton2,
    input  logic                i_boton3,
    output logic [BUS_SIZE-1:0] o_ALUout,
    output logic                o_carry
);

    typedef enum logic [OP_SIZE-1:0] {
        OP_ADD = OP_SIZE'(6'b100000),
        OP_SUB = OP_SIZE'(6'b100010),
        OP_AND = OP_SIZE'(6'b100100),
        OP_OR  = OP_SIZE'(6'b100101),
        OP_XOR = OP_SIZE'(6'b100110),
        OP_NOR = OP_SIZE'(6'b100111),
        OP_SRA = OP_SIZE'(6'b000011),
        OP_SRL = OP_SIZE'(6'b000010)
    } alu_op_e;

    logic [BUS_SIZE-1:0] reg_a;
    logic [BUS_SIZE-1:0] reg_b;
    logic [OP_SIZE-1:0]  reg_op;
    logic [BUS_SIZE:0]   result;
    logic                big_shift;

    // Buttons are level-sampled; every pressed button loads the same switch value.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (i_boton1) reg_a  <= i_swiches;
            if (i_boton2) reg_b  <= i_swiches;
            if (i_boton3) reg_op <= i_swiches[OP_SIZE-1:0];
        end
    end

    assign big_shift = (reg_b >= BUS_SIZE[BUS_SIZE-1:0]);

    always_comb begin
        result = '0;
        case (reg_op)
            OP_ADD: result = {1'b0, reg_a} + {1'b0, reg_b};
            OP_SUB: result = {1'b0, reg_a} - {1'b0, reg_b};
            OP_AND: result = {1'b0, reg_a & reg_b};
            OP_OR:  result = {1'b0, reg_a | reg_b};
            OP_XOR: result = {1'b0, reg_a ^ reg_b};
            OP_NOR: result = {1'b0, ~(reg_a | reg_b)};
            OP_SRA: begin
                if (big_shift)
                    result = {1'b0, {BUS_SIZE{reg_a[BUS_SIZE-1]}}};
                else
                    result = {1'b0, BUS_SIZE'($signed(reg_a) >>> reg_b)};
            end
            OP_SRL: begin
                if (big_shift)
                    result = '0;
                else
                    result = {1'b0, reg_a >> reg_b};
            end
            default: result = '0;
        endcase
    end

    assign o_ALUout = result[BUS_SIZE-1:0];
    assign o_carry  = result[BUS_SIZE];

endmodule

// File: tb/tb_my_alu_core.sv
// Directed plus randomized checks of my_alu_core against an integer-arithmetic
// reference model of the operand/opcode registers and ALU rules.
module tb_my_alu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sw  = '0;
    logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
    logic [7:0] alu_out;
    logic       carry;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_a = 0, m_b = 0, m_op = 0;

    my_alu_core #(.BUS_SIZE(8), .OP_SIZE(6)) dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_swiches(sw),
        .i_boton1 (b1),
        .i_boton2 (b2),
        .i_boton3 (b3),
        .o_ALUout (alu_out),
        .o_carry  (carry)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model(input int a, input int b, input int op);
        int s, sa, d, q;
        case (op)
            32: begin s = a + b; return {s > 255, 8'(s % 256)}; end
            34: begin s = a - b + 256; return {a < b, 8'(s % 256)}; end
            36: return {1'b0, 8'(a & b)};
            37: return {1'b0, 8'(a | b)};
            38: return {1'b0, 8'(a ^ b)};
            39: return {1'b0, 8'(255 - (a | b))};
            3: begin
                sa = (a >= 128) ? a - 256 : a;
                d  = (b >= 8) ? 256 : (1 << b);
                q  = sa / d;
                if (sa < 0 && q * d != sa) q = q - 1;   // floor division
                return {1'b0, 8'(q & 255)};
            end
            2: return {1'b0, 8'((b >= 8) ? 0 : a / (1 << b))};
            default: return 9'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed carry/out=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk(tag, {carry, alu_out}, model(m_a, m_b, m_op));
    endtask

    // Drive switches/buttons away from the edge, clock once, update model.
    task automatic step(input logic p1, input logic p2, input logic p3, input logic [7:0] v);
        @(negedge clk);
        sw = v; b1 = p1; b2 = p2; b3 = p3;
        @(posedge clk);
        #1;
        b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
        if (p1) m_a = int'(v);
        if (p2) m_b = int'(v);
        if (p3) m_op = int'(v) % 64;
    endtask

    task automatic load3(input int a, input int b, input int op);
        step(1'b1, 1'b0, 1'b0, 8'(a));
        step(1'b0, 1'b1, 1'b0, 8'(b));
        step(1'b0, 1'b0, 1'b1, 8'(op));
    endtask

    task automatic directed(input string tag, input int a, input int b, input int op,
                            input logic [8:0] exp);
        load3(a, b, op);
        chk(tag, {carry, alu_out}, exp);
    endtask

    logic [5:0] legal [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b100111, 6'b000011, 6'b000010};

    initial begin
        // Reset state
        rst = 1'b1;
        #12;
        chk("reset_out", {carry, alu_out}, 9'h000);
        @(negedge clk);
        rst = 1'b0;

        // ADD overflow
        directed("add_255_2", 255, 2, 32, 9'h101);
        step(1'b0, 1'b1, 1'b0, 8'd1);
        chk("add_255_1", {carry, alu_out}, 9'h100);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("add_255_0", {carry, alu_out}, 9'h0FF);

        // SUB
        directed("sub_10_4", 10, 4, 34, 9'h006);
        directed("sub_4_10", 4, 10, 34, 9'h1FA);
        directed("sub_7_7", 7, 7, 34, 9'h000);

        // Logic ops
        directed("and", 8'h37, 8'h65, 36, 9'h025);
        directed("or",  8'h37, 8'h65, 37, 9'h077);
        directed("xor", 8'h37, 8'h65, 38, 9'h052);
        directed("nor", 8'h37, 8'h65, 39, 9'h088);

        // Shifts
        directed("sra_2", 8'h80, 2, 3, 9'h0E0);
        step(1'b0, 1'b0, 1'b1, 8'd2);
        chk("srl_2", {carry, alu_out}, 9'h020);
        directed("sra_9", 8'h80, 9, 3, 9'h0FF);
        step(1'b0, 1'b0, 1'b1, 8'd2);
        chk("srl_9", {carry, alu_out}, 9'h000);
        step(1'b0, 1'b0, 1'b1, 8'h3F);
        chk("illegal_op", {carry, alu_out}, 9'h000);

        // Load control
        directed("pre_idle", 8'h12, 8'h34, 32, 9'h046);
        step(1'b0, 1'b0, 1'b0, 8'hAB);
        @(negedge clk); sw = 8'h5C; #2;
        chk("switch_idle", {carry, alu_out}, 9'h046);
        step(1'b1, 1'b1, 1'b0, 8'h11);
        chk("dual_button", {carry, alu_out}, 9'h022);
        step(1'b0, 1'b0, 1'b1, 8'hE0);
        chk("op_high_bits", {carry, alu_out}, 9'h022);

        // Asynchronous reset mid-sequence with a button held
        directed("pre_reset", 255, 2, 32, 9'h101);
        @(negedge clk);
        sw = 8'h55; b1 = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("reset_async", {carry, alu_out}, 9'h000);
        @(posedge clk); #1;
        chk("reset_hold_btn", {carry, alu_out}, 9'h000);
        @(negedge clk);
        b1 = 1'b0;
        #1 rst = 1'b0;
        m_a = 0; m_b = 0; m_op = 0;
        #1;
        chk("reset_release", {carry, alu_out}, 9'h000);
        directed("reload", 8'h40, 8'h03, 34, 9'h03D);

        // Randomized loads against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0] btn;
            logic [7:0] v;
            btn = 3'($urandom_range(0, 7));
            v   = 8'($urandom);
            if (btn[2] && $urandom_range(0, 3) != 0)
                v[5:0] = legal[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0)
                v[3:0] = 4'($urandom_range(0, 9));
            step(btn[0], btn[1], btn[2], v);
            check_model("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
